gate_input_debounce: RTL and testbench
======================================

// Module: gate_input_debounce
// PURPOSE
// - Input conditioning stage directly upstream of the 2-input logic gate blocks such as OR.
// - Takes two raw asynchronous inputs, typically board switches or buttons.
// - Synchronises each input, then debounces it.
// - Drives clean, glitch-free levels a/b straight into the gate's a/b inputs.
// - Two independent, identical channels; channel A (a_raw->a) and channel B (b_raw->b).
// PARAMETERS
// - SYNC_STAGES      2     synchroniser flop count per channel; legal >= 2
// - DEBOUNCE_CYCLES  1000  consecutive stable synced cycles required to accept a new level; legal >= 1
// - CNT_W            16    debounce counter width; must satisfy DEBOUNCE_CYCLES <= 2**CNT_W - 1
// PORTS
// - clk       input   1  system clock; all flops on posedge
// - rst       input   1  synchronous reset, active-high
// - a_raw     input   1  raw asynchronous input, channel A
// - b_raw     input   1  raw asynchronous input, channel B
// - a         output  1  debounced level A; feeds gate input a
// - b         output  1  debounced level B; feeds gate input b
// - settling  output  1  high while either channel is in SETTLING
// BEHAVIOUR
// - One clock, clk. Reset rst is synchronous and active-high.
// - rst asserted at a posedge clears all of the following:
//   - sync flops, counters and FSMs (-> STABLE)
//   - outputs: a=0, b=0, settling=0, plus a_rise/b_rise=0 when enabled
// - Sync chain: s = last stage of a SYNC_STAGES-deep shift register clocked from *_raw.
// - Per-channel 2-state FSM, held level q (= output), counter cnt:
//   - STABLE: s==q -> stay, cnt=0.
//   - STABLE: s!=q -> SETTLING, cnt=1.
//   - SETTLING: s==q (glitch ended) -> STABLE, cnt=0, q unchanged.
//   - SETTLING: s!=q and cnt<DEBOUNCE_CYCLES-1 -> cnt=cnt+1.
//   - SETTLING: s!=q and cnt==DEBOUNCE_CYCLES-1 -> q=s, cnt=0, STABLE.
// - DEBOUNCE_CYCLES=1 special case:
//   - STABLE with s!=q accepts immediately: q=s in the same cycle, no SETTLING.
// - Latency: a raw change held stable updates the output on posedge number SYNC_STAGES+DEBOUNCE_CYCLES after it.
//   - Default parameters give 1002 cycles.
// - Rejection: any synced pulse shorter than DEBOUNCE_CYCLES cycles leaves the output unchanged.
//   - This covers glitches of either polarity.
// - cnt never wraps: it saturates by construction at DEBOUNCE_CYCLES-1.
// - Channels are fully independent.
//   - Simultaneous changes on a_raw and b_raw each settle on their own schedule.
//   - Identical timing gives identical update cycles.
// - settling = (FSM_A==SETTLING) | (FSM_B==SETTLING); registered, same cycle as FSM state.
// - Reset mid-SETTLING discards progress.
//   - After release, a held-high input needs the full SYNC_STAGES+DEBOUNCE_CYCLES again.
// - Outputs are registered only; no combinational path from *_raw to a/b.
// CONFIGURATION
// - Macro GATE_DEBOUNCE_EDGE_EN.
// - Defined: adds outputs a_rise and b_rise (output, 1 bit each).
//   - Each is a 1-cycle pulse, registered, high in the first cycle its output reads 1 after a 0->1 acceptance.
//   - No pulse on 1->0 acceptance.
//   - No pulse on reset release.
// - Undefined: a_rise/b_rise ports and their logic are absent.
//   - All other behaviour is identical.
// TESTING
// Bench parameters for all cases: SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// - Case 1, reset.
//   - Stimulus: rst=1 for 3 cycles, a_raw=b_raw=1.
//   - Required: a=b=0, settling=0 throughout reset.
//   - Required after release: a=1 on the 6th posedge following release.
// - Case 2, clean step.
//   - Stimulus: a_raw 0->1, held.
//   - Required: a rises exactly 6 posedges later; settling high for cycles 3-5; b stays 0.
// - Case 3, glitch rejection.
//   - Stimulus: a_raw high for 3 cycles, then 0.
//   - Required: a stays 0; settling pulses and returns to 0.
//   - Stimulus, repeat: high for 4 cycles.
//   - Required: a=1.
// - Case 4, simultaneous changes.
//   - Stimulus: a_raw and b_raw both 0->1 on the same cycle.
//   - Required: a and b rise on the same posedge, 6 later.
//   - Stimulus: then b_raw->0 for 10 cycles.
//   - Required: only b falls.
// - Case 5, reset mid-operation.
//   - Stimulus: a_raw 0->1; rst pulsed 1 cycle at posedge 4.
//   - Required: a stays 0 until 6 posedges after rst release.
// - Case 6, edge pulses (GATE_DEBOUNCE_EDGE_EN defined).
//   - Stimulus: clean step on a_raw.
//   - Required: a_rise=1 for exactly 1 cycle, coincident with the first cycle a=1.
//   - Stimulus: falling step.
//   - Required: no pulse.

Source files
------------

// File: rtl/gate_input_debounce.sv
// gate_input_debounce
// Two-channel synchronise-and-debounce front end for raw switch/button
// inputs feeding a 2-input logic gate. Each channel has a SYNC_STAGES-deep
// synchroniser and a two-state STABLE/SETTLING FSM with a hold counter.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive cycles of
// the synchronised input disagreeing with the held level.
// Optional feature: define GATE_DEBOUNCE_EDGE_EN to add the a_rise/b_rise
// one-cycle pulses that mark a 0->1 acceptance.
module gate_input_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic settling
`ifdef GATE_DEBOUNCE_EDGE_EN
    ,
    output logic a_rise,
    output logic b_rise
`endif
);

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } state_t;

    // Counter value on the final settling cycle; saturation point of cnt.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] raw_vec;
    assign raw_vec = {b_raw, a_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic                   s;
        state_t                 state;
        state_t                 state_nxt;
        logic [CNT_W-1:0]       cnt;
        logic [CNT_W-1:0]       cnt_nxt;
        logic                   q;
        logic                   q_nxt;

        // Shift the raw input through the synchroniser chain.
        always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge value of its neighbours.
            if (rst) begin
                sync <= '0;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], raw_vec[ch]};
            end
        end

        assign s = sync[SYNC_STAGES-1];

        // Debounce next-state logic: accept s only after it has disagreed
        // with the held level for DEBOUNCE_CYCLES consecutive cycles.
        always_comb begin
            // NOTE: every output of this block gets a default first, so no path
            // leaves a signal unassigned and no latch is inferred.
            state_nxt = state;
            cnt_nxt   = cnt;
            q_nxt     = q;
            case (state)
                STABLE: begin
                    cnt_nxt = '0;
                    if (s != q) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            q_nxt = s;
                        end else begin
                            state_nxt = SETTLING;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                SETTLING: begin
                    if (s == q) begin
                        // Glitch ended before the hold time; keep the old level.
                        state_nxt = STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        q_nxt     = s;
                        state_nxt = STABLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // FSM state, counter and held level registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                state <= STABLE;
                cnt   <= '0;
                q     <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                q     <= q_nxt;
            end
        end
    end

    assign a = g_ch[0].q;
    assign b = g_ch[1].q;

    // Registered settling flag, aligned with the FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            settling <= 1'b0;
        end else begin
            settling <= (g_ch[0].state_nxt == SETTLING) |
                        (g_ch[1].state_nxt == SETTLING);
        end
    end

`ifdef GATE_DEBOUNCE_EDGE_EN
    // One-cycle pulse in the first cycle a held level reads 1 after a 0->1 accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rise <= 1'b0;
            b_rise <= 1'b0;
        end else begin
            a_rise <= g_ch[0].q_nxt & ~g_ch[0].q;
            b_rise <= g_ch[1].q_nxt & ~g_ch[1].q;
        end
    end
`endif

endmodule

// File: tb/tb_gate_input_debounce.sv
// tb_gate_input_debounce
// Directed bench for gate_input_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled 1 time unit after each posedge, so
// "step k" below is the k-th posedge after the stimulus change.
// Define GATE_DEBOUNCE_EDGE_EN to also exercise the a_rise/b_rise pulses.
module tb_gate_input_debounce;

    logic clk;
    logic rst;
    logic a_raw;
    logic b_raw;
    logic a;
    logic b;
    logic settling;
`ifdef GATE_DEBOUNCE_EDGE_EN
    logic a_rise;
    logic b_rise;
`endif

    int total = 0;
    int bad   = 0;

    gate_input_debounce #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a_raw   (a_raw),
        .b_raw   (b_raw),
        .a       (a),
        .b       (b),
        .settling(settling)
`ifdef GATE_DEBOUNCE_EDGE_EN
        ,
        .a_rise  (a_rise),
        .b_rise  (b_rise)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one posedge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Case 1: reset with both raw inputs high.
        rst   = 1'b1;
        a_raw = 1'b1;
        b_raw = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("c1_rst_a", a, 1'b0);
            check("c1_rst_b", b, 1'b0);
            check("c1_rst_settling", settling, 1'b0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("c1_rel_a", a, (k == 6));
            check("c1_rel_b", b, (k == 6));
            check("c1_rel_settling", settling, (k >= 3 && k <= 5));
        end
        a_raw = 1'b0;
        b_raw = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("c1_fall_a", a, (k < 6));
            check("c1_fall_b", b, (k < 6));
        end
        step();

        // Case 2: clean step on channel A only.
        a_raw = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("c2_a", a, (k >= 6));
            check("c2_settling", settling, (k >= 3 && k <= 5));
            check("c2_b", b, 1'b0);
        end
        a_raw = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("c2_fall_a", a, (k < 6));
        end

        // Case 3a: 3-cycle high glitch is rejected.
        a_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 3) a_raw = 1'b0;
            check("c3_glitch_a", a, 1'b0);
            check("c3_glitch_settling", settling, (k >= 3 && k <= 5));
        end

        // Case 3b: 4-cycle high pulse is accepted, then the return low is accepted.
        a_raw = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 4) a_raw = 1'b0;
            check("c3_pulse_a", a, (k >= 6 && k <= 9));
        end
        step();

        // Case 4: simultaneous rise, then only B falls.
        a_raw = 1'b1;
        b_raw = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("c4_rise_a", a, (k == 6));
            check("c4_rise_b", b, (k == 6));
        end
        b_raw = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("c4_hold_a", a, 1'b1);
            check("c4_fall_b", b, (k < 6));
        end
        a_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("c4_end_a", a, (k < 6));
            check("c4_end_b", b, 1'b0);
        end

        // Case 5: reset mid-settling discards progress.
        a_raw = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("c5_pre_a", a, 1'b0);
            check("c5_pre_settling", settling, (k == 3));
        end
        rst = 1'b1;
        step();
        check("c5_rst_a", a, 1'b0);
        check("c5_rst_settling", settling, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("c5_rel_a", a, (k >= 6));
            check("c5_rel_settling", settling, (k >= 3 && k <= 5));
        end

`ifdef GATE_DEBOUNCE_EDGE_EN
        // Case 6: rise pulse on 0->1 only.
        a_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("c6_drop_a", a, (k < 6));
            check("c6_drop_rise", a_rise, 1'b0);
        end
        a_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("c6_step_a", a, (k >= 6));
            check("c6_step_rise", a_rise, (k == 6));
            check("c6_step_b_rise", b_rise, 1'b0);
        end
        a_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("c6_fall_a", a, (k < 6));
            check("c6_fall_rise", a_rise, 1'b0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
